mux_r_in_banco: RTL
===================

Name: mux_r_in_banco

Overview:
- Parametrised successor to the register-input multiplexer, with the register bank folded into the block.
- Each cycle it selects one of four sources: register read (RY), external input, ALU result or immediate.
- The selected value is captured in a pipeline register, then written into a 2^AW x DW register bank.
- Read-after-write forwarding is provided on the RY read port.
- Sits between the instruction decoder/ALU and the datapath register file of the 8-bit micro.

Parameters:
- DW, 8, data width of every source, bank entry and output.
- AW, 3, register address width; the bank holds 2^AW entries.
- R0_CERO, 0, when 1 register 0 always reads 0 and writes to it are discarded.
- RST_VAL, 0, value loaded into every bank entry and into DATO on reset.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- RY  in  AW  read address; its data is source 0 and also drives RY_DATO.
- DATO_IN  in  DW  external input port data (source 1).
- ALU_IN  in  DW  ALU result (source 2).
- INM  in  DW  immediate from instruction (source 3).
- SELEC  in  2  source select: 00 RY_DATO, 01 DATO_IN, 10 ALU_IN, 11 INM.
- RX  in  AW  destination register address.
- WE  in  1  write request this cycle.
- PARA  in  1  stall: freezes the pipeline register.
- RY_DATO  out  DW  combinational read of bank[RY], with forwarding.
- DATO  out  DW  registered selected value (pipeline stage).
- DATO_VALID  out  1  DATO holds a pending write.
- RX_Q  out  AW  registered destination address for DATO.

Behaviour:
- Reset, asynchronous and taking priority over everything:
  - every bank entry = RST_VAL;
  - DATO = RST_VAL, DATO_VALID = 0, RX_Q = 0.
  - Reset asserted mid-operation discards a pending write; it never reaches the bank.
- Stage 1 (capture): at a rising edge with PARA=0:
  - DATO <= mux(SELEC);
  - RX_Q <= RX;
  - DATO_VALID <= WE.
- Stage 1 under stall: with PARA=1, DATO, RX_Q and DATO_VALID hold their values.
- Stage 2 (write): at a rising edge with PARA=0 and DATO_VALID=1, bank[RX_Q] <= DATO.
  - Skipped when R0_CERO=1 and RX_Q=0.
  - A stalled pending write is not committed; it is committed on the first unstalled edge.
- Latency: WE sampled at edge n.
  - DATO/DATO_VALID are visible after edge n.
  - The bank is updated at edge n+1.
  - The value is visible through bank reads from n+1 onward.
- Forwarding: when DATO_VALID=1 and RX_Q==RY, RY_DATO = DATO. Otherwise RY_DATO = bank[RY].
  - R0_CERO=1 and RY=0 forces RY_DATO = 0, overriding forwarding.
- Source 0 uses the forwarded RY_DATO, so back-to-back moves (write R2, then R3<=R2) are correct with no bubble.
- Simultaneous events: a new capture and a commit of the previous write in the same edge are normal pipelined operation.
  - If the new RX equals RX_Q, the later write wins on the following edge.
- WE=0 still updates DATO, but DATO_VALID=0, so no write and no forwarding.
- Widths: all sources exactly DW; no extension or truncation. RX/RY wrap naturally within 2^AW.
- No X propagation: SELEC covers all four codes.

Test Plan:
- Reset:
  - Stimulus: RST=1 mid-run with DATO_VALID=1 and RX_Q=5; release; read RY=5.
  - Required: RY_DATO=8'h00, DATO_VALID=0, DATO=8'h00 immediately on RST rise, without waiting for a clock edge.
- Source select: RX=1, WE=1, over consecutive cycles SELEC=01 with DATO_IN=8'h0F, then RX=2 SELEC=10 ALU_IN=8'hAA, then RX=3 SELEC=11 INM=8'h55.
  - Required: after settling, RY=1/2/3 read 8'h0F/8'hAA/8'h55.
- Forwarding:
  - Stimulus: write R5=8'hAA; next cycle RY=5, SELEC=00, RX=6, WE=1.
  - Required: RY_DATO=8'hAA in the cycle before the bank commit; R6 ends up 8'hAA.
- Stall:
  - Stimulus: PARA=1 for 3 cycles with DATO_VALID=1, RX_Q=4, DATO=8'h3C, while inputs change.
  - Required: DATO, RX_Q and DATO_VALID hold; R4 remains old; R4=8'h3C one edge after PARA drops.
- R0_CERO=1:
  - Stimulus: write R0=8'hFF.
  - Required: RY=0 reads 8'h00 both during forwarding and afterwards; other registers are unaffected.
- Same-address back-to-back: RX=7 with DATO_IN=8'h11, then RX=7 with DATO_IN=8'h22.
  - Required: R7 ends at 8'h22; RY_DATO for RY=7 shows 8'h11 then 8'h22.

Source files
------------

// File: rtl/mux_r_in_banco.sv
// Source mux into a one-stage pipeline register that commits into a 2^AW x DW bank; RY reads forward the pending write.
// Latency: capture at edge n, bank commit at edge n+1; PARA=1 freezes both the pipeline register and a pending commit.
module mux_r_in_banco #(
    parameter int              DW      = 8,
    parameter int              AW      = 3,
    parameter int              R0_CERO = 0,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] RY,
    input  logic [DW-1:0] DATO_IN,
    input  logic [DW-1:0] ALU_IN,
    input  logic [DW-1:0] INM,
    input  logic [1:0]    SELEC,
    input  logic [AW-1:0] RX,
    input  logic          WE,
    input  logic          PARA,
    output logic [DW-1:0] RY_DATO,
    output logic [DW-1:0] DATO,
    output logic          DATO_VALID,
    output logic [AW-1:0] RX_Q
);

    localparam int NREG  = 1 << AW;
    localparam bit R0_EN = (R0_CERO != 0);

    logic [DW-1:0] bank [NREG];
    logic [DW-1:0] sel_val;
    logic          commit;

    // Zero-register override wins over forwarding so R0 never leaks a discarded write.
    always_comb begin
        RY_DATO = bank[RY];
        if (DATO_VALID && (RX_Q == RY))
            RY_DATO = DATO;
        if (R0_EN && (RY == '0))
            RY_DATO = '0;
    end

    always_comb begin
        sel_val = RY_DATO;
        case (SELEC)
            2'b00: sel_val = RY_DATO;
            2'b01: sel_val = DATO_IN;
            2'b10: sel_val = ALU_IN;
            2'b11: sel_val = INM;
        endcase
    end

    assign commit = !PARA && DATO_VALID && !(R0_EN && (RX_Q == '0));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DATO       <= RST_VAL;
            DATO_VALID <= 1'b0;
            RX_Q       <= '0;
        end else if (!PARA) begin
            DATO       <= sel_val;
            DATO_VALID <= WE;
            RX_Q       <= RX;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++)
                bank[i] <= RST_VAL;
        end else if (commit) begin
            bank[RX_Q] <= DATO;
        end
    end

endmodule
